error_accumulator: RTL
======================

# error_accumulator

Streaming scoring stage directly downstream of `forward_propagation`. It consumes one (actual label, predicted output) pair per handshake and accumulates the sum of squared error and the count of exact matches over a batch of `ROWS` samples. It pulses `done` when the batch total is final. It is the synthesizable, clocked replacement for the batch-end accuracy loop in the prediction stage.

## Interface
- `ROWS`, 100: samples per batch (≥1).
- `DATA_W`, 8: width of `actual` / `predicted`, two's-complement signed.
- `ACC_W`, 32: width of the `sse` accumulator.
- `CNT_W`, `$clog2(ROWS+1)`: width of the sample and match counters.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a new batch; sampled only in IDLE or DONE.
- `in_valid`  in  1  upstream pair valid.
- `in_ready`  out  1  block accepts a pair this cycle.
- `actual`  in  DATA_W  label, signed.
- `predicted`  in  DATA_W  network output, signed.
- `sse`  out  ACC_W  sum of (actual−predicted)², unsigned, saturating.
- `correct`  out  CNT_W  count of pairs with actual==predicted.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse; `sse`/`correct` final.
- `overflow`  out  1  sticky; `sse` saturated this batch.

## Operation
- FSM: IDLE → (start) RUN → (ROWS pairs accepted) DRAIN → (pipeline empty) DONE → IDLE.
  - DONE lasts exactly 1 cycle. `start` seen in DONE goes straight to RUN.
- On accepted `start`: clear `sse`, `correct`, `overflow`, and the accept counter.
- `in_ready` = (state==RUN) && (accepted < ROWS). A transfer happens when `in_valid && in_ready`.
- Pipeline:
  - S1 registers `diff = actual − predicted`, sign-extended to DATA_W+1, and `match = (actual==predicted)`.
  - S2 registers `sq = diff*diff`, unsigned, 2·(DATA_W+1) bits, plus the delayed match.
  - S3 adds `sq` to `sse` and `match` to `correct`.
- Saturation: if `sse + sq` exceeds 2^ACC_W−1, `sse` takes the all-ones value and `overflow` sets. It stays set until the next start or reset.
- `start` is ignored in RUN and DRAIN.
- `sse`, `correct` and `overflow` hold their values from DONE until the next accepted start.
- `in_valid` while not ready: the pair is not consumed and nothing changes.
- Reset mid-batch: the pipeline is squashed, all state is cleared, and the FSM returns to IDLE. No `done` is produced for the aborted batch.

## Timing
- Reset values: `in_ready`=0, `sse`=0, `correct`=0, `busy`=0, `done`=0, `overflow`=0; state IDLE.
- Throughput: one pair per cycle while `in_valid` is held.
- Latency: a pair accepted at edge E0 reaches S1 at E0, S2 at E1 and the accumulator at E2.
- Completion:
  - The last (ROWS-th) pair is accepted at edge L. The FSM enters DRAIN at L.
  - The FSM enters DONE at L+2; `done` is high in the cycle after L+2.
  - `sse`/`correct` already include the last pair in that cycle.
  - With a continuous `in_valid` stream, `done` rises ROWS+2 edges after the start edge plus one.
- Start edge S: clears take effect at S. `in_ready` is high from the cycle after S.
- `busy` is high from the cycle after S through the cycle before `done`.
- Start coincident with `done` (start=1 in the DONE cycle): the new batch begins and `done` still pulses for exactly that one cycle.
- Start and reset in the same cycle: reset wins.

## Test plan
- Reset then idle: assert `rst` for 2 cycles, hold `in_valid`=1 → `in_ready`=0, all outputs 0, `done` never rises.
- ROWS=4, pairs (3,3) (5,2) (−4,4) (0,−1), continuous `in_valid` → `done` pulses 1 cycle with `sse`=0+9+64+1=74, `correct`=1, `overflow`=0. The pulse falls at start edge+7.
- Back-pressure: same batch with `in_valid` toggling every other cycle → identical `sse`=74, `correct`=1. `in_ready` drops after the 4th accept and exactly 4 pairs are consumed.
- Saturation: ACC_W=8, ROWS=3, pairs (−128,127) ×3 → each sq=65025. `sse`=255 and `overflow`=1 at `done`.
- Mid-batch reset: after 2 of 4 pairs, assert `rst` → next cycle IDLE with zeroed outputs and no `done`. A subsequent full batch gives correct totals.
- Back-to-back batches: `start`=1 in the DONE cycle, second batch of ROWS pairs (1,1) → second `done` shows `sse`=0, `correct`=ROWS, `overflow`=0, with no carry-over from batch 1.

Source files
------------

// File: rtl/error_accumulator.sv
// ---------------------------------------------------------------------------
// error_accumulator
//
// Streaming scoring stage that sits behind forward_propagation. Each accepted
// (actual, predicted) pair flows through a three-stage pipeline:
//   S1: signed difference and exact-match flag
//   S2: squared difference (always non-negative)
//   S3: saturating add into the running sum of squared error, plus the
//       match counter
// Once ROWS pairs have been accepted and the pipeline has drained, the block
// pulses done_o for one cycle. The totals then hold until the next start.
//
// Ports:
//   clk_i         clock, everything on the rising edge
//   rst_i         synchronous active-high reset
//   start_i       begin a new batch (honoured only in IDLE or DONE)
//   in_valid_i    upstream pair valid
//   in_ready_o    a pair is accepted this cycle when in_valid_i is also high
//   actual_i      label, two's-complement
//   predicted_i   network output, two's-complement
//   sse_o         saturating sum of (actual - predicted)^2
//   correct_o     number of pairs with actual == predicted
//   busy_o        high while collecting or draining a batch
//   done_o        one-cycle pulse, totals are final
//   overflow_o    sticky flag, sse_o saturated during this batch
// ---------------------------------------------------------------------------
module error_accumulator #(
    parameter int ROWS   = 100,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = $clog2(ROWS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] actual_i,
    input  logic [DATA_W-1:0] predicted_i,
    output logic [ACC_W-1:0]  sse_o,
    output logic [CNT_W-1:0]  correct_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int SQ_W   = 2 * DIFF_W;
    // The adder is wide enough for either operand plus a carry, so a single
    // check of the bits above ACC_W tells us the true sum overflowed.
    localparam int SUM_W  = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         acc_cnt_q, acc_cnt_d;

    logic                     s1_valid_q;
    logic signed [DIFF_W-1:0] s1_diff_q, s1_diff_d;
    logic                     s1_match_q;

    logic                     s2_valid_q;
    logic [SQ_W-1:0]          s2_sq_q, s2_sq_d;
    logic                     s2_match_q;

    logic [ACC_W-1:0]         sse_q, sse_d;
    logic [CNT_W-1:0]         correct_q, correct_d;
    logic                     overflow_q, overflow_d;

    logic                     accept;
    logic                     start_ok;
    logic signed [SQ_W-1:0]   diff_ext;
    logic signed [SQ_W-1:0]   prod;
    logic [SUM_W-1:0]         sum_w;

    // Handshake and start qualification. A start is only honoured once the
    // previous batch has fully reported, so it cannot corrupt totals in flight.
    always_comb begin
        in_ready_o = (state_q == RUN) && (acc_cnt_q < CNT_W'(ROWS));
        accept     = in_valid_i && in_ready_o;
        start_ok   = start_i && ((state_q == IDLE) || (state_q == DONE));
        busy_o     = (state_q == RUN) || (state_q == DRAIN);
        done_o     = (state_q == DONE);
    end

    // Next-state logic. DRAIN waits until S1 is empty: the last pair is then
    // sitting in S2 and is accumulated on the very edge that enters DONE.
    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && (acc_cnt_q == CNT_W'(ROWS - 1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start_i ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (start_ok) begin
            acc_cnt_d = '0;
        end else if (accept) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
    end

    // Datapath next values: difference, square, and the saturating
    // accumulation. The square of a DIFF_W-bit value is non-negative and fits
    // in SQ_W bits, so the low SQ_W bits of the signed product are exact.
    always_comb begin
        s1_diff_d = $signed({actual_i[DATA_W-1], actual_i})
                  - $signed({predicted_i[DATA_W-1], predicted_i});
        diff_ext  = SQ_W'(s1_diff_q);
        prod      = diff_ext * diff_ext;
        s2_sq_d   = prod;
        sum_w     = SUM_W'(sse_q) + SUM_W'(s2_sq_q);

        sse_d      = sse_q;
        correct_d  = correct_q;
        overflow_d = overflow_q;
        if (start_ok) begin
            sse_d      = '0;
            correct_d  = '0;
            overflow_d = 1'b0;
        end else if (s2_valid_q) begin
            correct_d = correct_q + CNT_W'(s2_match_q);
            if (|sum_w[SUM_W-1:ACC_W]) begin
                sse_d      = '1;
                overflow_d = 1'b1;
            end else begin
                sse_d = sum_w[ACC_W-1:0];
            end
        end
    end

    // State, pipeline and accumulator registers. Reset squashes the pipeline
    // valids so an aborted batch leaves nothing behind to accumulate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            acc_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_match_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sq_q    <= '0;
            s2_match_q <= 1'b0;
            sse_q      <= '0;
            correct_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            s1_valid_q <= accept;
            if (accept) begin
                s1_diff_q  <= s1_diff_d;
                s1_match_q <= (actual_i == predicted_i);
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sq_q    <= s2_sq_d;
                s2_match_q <= s1_match_q;
            end
            sse_q      <= sse_d;
            correct_q  <= correct_d;
            overflow_q <= overflow_d;
        end
    end

    assign sse_o      = sse_q;
    assign correct_o  = correct_q;
    assign overflow_o = overflow_q;

endmodule
